// File: rtl/rst_seq.sv
// Reset sequencer: asynchronous assertion, synchronised release, a stretch period,
// then staggered release of NUM_OUT active-low outputs. All flops use the falling clock edge.
module rst_seq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_OUT     = 3,
  parameter int unsigned STRETCH     = 16,
  parameter int unsigned GAP         = 4
) (
  input  logic               clk,
  input  logic               sys_rst_n,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               rst_done,
  output logic               soft_cause
);

  localparam int unsigned MAX_CNT = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);
  localparam int unsigned IW      = (NUM_OUT > 1) ? $clog2(NUM_OUT + 1) : 1;

  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_STRETCH,
    ST_RELEASE,
    ST_DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_n;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;

  assign sync_n = sync[SYNC_STAGES-1];

  always_ff @(negedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(negedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_ASSERT;
      cnt        <= '0;
      idx        <= '0;
      rst_n_out  <= '0;
      rst_done   <= 1'b0;
      soft_cause <= 1'b0;
    end else if (sw_rst_req && (state != ST_ASSERT)) begin
      state      <= ST_STRETCH;
      cnt        <= '0;
      idx        <= '0;
      rst_n_out  <= '0;
      rst_done   <= 1'b0;
      soft_cause <= 1'b1;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (sync_n) begin
            if (STRETCH == 1) begin
              rst_n_out[0] <= 1'b1;
              idx          <= IW'(1);
              cnt          <= '0;
              state        <= (NUM_OUT == 1) ? ST_DONE : ST_RELEASE;
            end else begin
              // The entry edge already counts as the first stretch edge, so the
              // first release lands SYNC_STAGES + STRETCH edges after reset release.
              cnt   <= CW'(1);
              state <= ST_STRETCH;
            end
          end
        end
        ST_STRETCH: begin
          if (cnt == STRETCH_LAST) begin
            rst_n_out[0] <= 1'b1;
            idx          <= IW'(1);
            cnt          <= '0;
            state        <= (NUM_OUT == 1) ? ST_DONE : ST_RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt == GAP_LAST) begin
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
              if (idx == IW'(i)) begin
                rst_n_out[i] <= 1'b1;
              end
            end
            idx <= idx + IW'(1);
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state <= ST_DONE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          rst_done <= 1'b1;
        end
        default: begin
          state <= ST_ASSERT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq.sv
// Randomised bench for rst_seq: default instance plus a minimal-parameter instance,
// both compared each cycle against an edge-count model of the release schedule.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       sw_rst_req;
  logic [2:0] out_a;
  logic       done_a, soft_a;
  logic [0:0] out_b;
  logic       done_b, soft_b;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  always #5 clk = ~clk;

  rst_seq u_dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .sw_rst_req (sw_rst_req),
    .rst_n_out  (out_a),
    .rst_done   (done_a),
    .soft_cause (soft_a)
  );

  rst_seq #(
    .SYNC_STAGES (3),
    .NUM_OUT     (1),
    .STRETCH     (1),
    .GAP         (1)
  ) u_sweep (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .sw_rst_req (sw_rst_req),
    .rst_n_out  (out_b),
    .rst_done   (done_b),
    .soft_cause (soft_b)
  );

  // Model: per instance, edges since hardware release (n) or since the last
  // accepted software request (m); outputs follow directly from thresholds.
  int p_sync [2] = '{2, 3};
  int p_num  [2] = '{3, 1};
  int p_str  [2] = '{16, 1};
  int p_gap  [2] = '{4, 1};
  int n_e    [2];
  int m_e    [2];
  bit sw_md  [2];
  bit soft_m [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      n_e[k] = 0; m_e[k] = 0; sw_md[k] = 1'b0; soft_m[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!sys_rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_e[k] = n_e[k] + 1;
        if (sw_rst_req && (sw_md[k] || n_e[k] >= p_sync[k] + 2)) begin
          sw_md[k] = 1'b1; m_e[k] = 0; soft_m[k] = 1'b1;
        end else if (sw_md[k]) begin
          m_e[k] = m_e[k] + 1;
        end
      end
    end
  end

  function automatic logic [31:0] exp_out(int k);
    logic [31:0] v = '0;
    int base = sw_md[k] ? p_str[k] : p_sync[k] + p_str[k];
    int cnt  = sw_md[k] ? m_e[k] : n_e[k];
    for (int i = 0; i < p_num[k]; i++) v[i] = (cnt >= base + i * p_gap[k]);
    return v;
  endfunction

  function automatic logic [31:0] exp_done(int k);
    int base = sw_md[k] ? p_str[k] : p_sync[k] + p_str[k];
    int cnt  = sw_md[k] ? m_e[k] : n_e[k];
    return {31'b0, cnt >= base + (p_num[k] - 1) * p_gap[k] + 1};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check("a_rst_n_out", {29'b0, out_a},  exp_out(0));
    check("a_rst_done",  {31'b0, done_a}, exp_done(0));
    check("a_soft",      {31'b0, soft_a}, {31'b0, soft_m[0]});
    check("b_rst_n_out", {31'b0, out_b},  exp_out(1));
    check("b_rst_done",  {31'b0, done_b}, exp_done(1));
    check("b_soft",      {31'b0, soft_b}, {31'b0, soft_m[1]});
  endtask

  task automatic step(input bit req);
    @(posedge clk);
    #1 check_all();
    #1 sw_rst_req = req;
  endtask

  task automatic hw_low();
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check("async_out_a",  {29'b0, out_a}, '0);
    check("async_done_a", {31'b0, done_a}, '0);
    check("async_soft_a", {31'b0, soft_a}, '0);
    check("async_out_b",  {31'b0, out_b}, '0);
  endtask

  task automatic hw_reset(input int cycles);
    hw_low();
    repeat (cycles) step(1'b0);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n  = 1'b0;
    sw_rst_req = 1'b0;
    model_reset();
    repeat (5) step(1'b0);
    sys_rst_n = 1'b1;
    repeat (30) step(1'b0);

    hw_reset(3);
    repeat (22) step(1'b0);
    hw_low();
    repeat (2) step(1'b0);
    sys_rst_n = 1'b1;
    repeat (30) step(1'b0);

    step(1'b1);
    repeat (30) step(1'b0);

    hw_reset(2);
    repeat (19) step(1'b0);
    repeat (10) step(1'b1);
    repeat (25) step(1'b0);

    hw_reset(2);
    step(1'b1);
    repeat (30) step(1'b0);

    for (int ep = 0; ep < 40; ep++) begin
      case ($urandom_range(0, 5))
        0: begin
          hw_low();
          sys_rst_n = 1'b1;
        end
        1: hw_reset($urandom_range(1, 4));
        default: ;
      endcase
      for (int c = 0, lim = $urandom_range(5, 40); c < lim; c++) begin
        step($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) step(1'b1);
    end
    step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
